// File: rtl/vespa_loop_sr.sv
// Loop-control shift register: WIDTH-bit x DEPTH-stage chain with a programmable
// tap, hold/shift/rotate/clear modes, tap-window occupancy and a rotation lap pulse.
module vespa_loop_sr #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [LW-1:0]    len,
    input  logic [WIDTH-1:0] i0,
    input  logic             i0_valid,
    output logic [WIDTH-1:0] sr,
    output logic             sr_valid,
    output logic [LW-1:0]    occ,
    output logic             full,
    output logic             empty,
    output logic             lap
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    pos_q;
    logic             lap_q;
    logic [LW-1:0]    len_c;
    logic [LW-1:0]    len_m1;
    logic [IW-1:0]    tap;
    logic [LW-1:0]    occ_c;

    // len_q is always in 1..DEPTH, so the tap index never leaves the array
    assign len_m1 = len_q - LW'(1);
    assign tap    = IW'(len_m1);

    always_comb begin
        len_c = len;
        if (len == '0) begin
            len_c = LW'(1);
        end else if (len > DEPTH_L) begin
            len_c = DEPTH_L;
        end
    end

    always_comb begin
        occ_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (LW'(i) < len_q) begin
                occ_c = occ_c + LW'(valid_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
            len_q   <= DEPTH_L;
            pos_q   <= '0;
            lap_q   <= 1'b0;
        end else begin
            case (mode)
                MODE_SHIFT: begin
                    data_q[0] <= i0;
                    for (int k = 1; k < DEPTH; k++) begin
                        data_q[k] <= data_q[k-1];
                    end
                    valid_q <= {valid_q[DEPTH-2:0], i0_valid};
                    pos_q   <= '0;
                    lap_q   <= 1'b0;
                end
                MODE_ROTATE: begin
                    data_q[0] <= data_q[tap];
                    for (int k = 1; k < DEPTH; k++) begin
                        data_q[k] <= data_q[k-1];
                    end
                    valid_q <= {valid_q[DEPTH-2:0], valid_q[tap]};
                    if (pos_q == len_m1) begin
                        pos_q <= '0;
                        lap_q <= 1'b1;
                    end else begin
                        pos_q <= pos_q + LW'(1);
                        lap_q <= 1'b0;
                    end
                end
                MODE_CLEAR: begin
                    for (int k = 0; k < DEPTH; k++) begin
                        data_q[k] <= '0;
                    end
                    valid_q <= '0;
                    len_q   <= len_c;
                    pos_q   <= '0;
                    lap_q   <= 1'b0;
                end
                default: begin
                    lap_q <= 1'b0;
                end
            endcase
        end
    end

    assign sr       = data_q[tap];
    assign sr_valid = valid_q[tap];
    assign occ      = occ_c;
    assign full     = (occ_c == len_q);
    assign empty    = (occ_c == '0);
    assign lap      = lap_q;

endmodule

// File: tb/tb_vespa_loop_sr.sv
// Directed bench for vespa_loop_sr: expected outputs are queued when each step is
// driven and popped/compared one cycle later against the DUT.
module tb_vespa_loop_sr;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] SHIFT  = 2'b01;
    localparam logic [1:0] ROTATE = 2'b10;
    localparam logic [1:0] CLEAR  = 2'b11;

    logic             clk;
    logic             rst_n;
    logic [1:0]       mode;
    logic [LW-1:0]    len;
    logic [WIDTH-1:0] i0;
    logic             i0_valid;
    logic [WIDTH-1:0] sr;
    logic             sr_valid;
    logic [LW-1:0]    occ;
    logic             full;
    logic             empty;
    logic             lap;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] sr;
        logic             srv;
        logic [LW-1:0]    occ;
        logic             full;
        logic             empty;
        logic             lap;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    vespa_loop_sr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .len      (len),
        .i0       (i0),
        .i0_valid (i0_valid),
        .sr       (sr),
        .sr_valid (sr_valid),
        .occ      (occ),
        .full     (full),
        .empty    (empty),
        .lap      (lap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string tag, input logic [7:0] s, input logic v,
                                input logic [4:0] o, input logic f, input logic e,
                                input logic l);
        exp_t x;
        x.tag = tag; x.sr = s; x.srv = v; x.occ = o; x.full = f; x.empty = e; x.lap = l;
        return x;
    endfunction

    task automatic check_pop();
        exp_t e;
        logic [17:0] obs;
        logic [17:0] req;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed no entry, required one entry");
            return;
        end
        e   = sb.pop_front();
        obs = {sr, sr_valid, occ, full, empty, lap};
        req = {e.sr, e.srv, e.occ, e.full, e.empty, e.lap};
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed sr=%h v=%b occ=%0d full=%b empty=%b lap=%b, required sr=%h v=%b occ=%0d full=%b empty=%b lap=%b",
                   e.tag, sr, sr_valid, occ, full, empty, lap,
                   e.sr, e.srv, e.occ, e.full, e.empty, e.lap);
        end
    endtask

    task automatic step(input logic [1:0] m, input logic [4:0] l, input logic [7:0] d,
                        input logic v, input exp_t e);
        mode = m; len = l; i0 = d; i0_valid = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        rst_n = 1'b1; mode = HOLD; len = '0; i0 = '0; i0_valid = 1'b0;

        // asynchronous reset between edges
        #12 rst_n = 1'b0;
        #1;
        sb.push_back(mk("reset_async", 8'h00, 0, 0, 0, 1, 0));
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // len_q = 16 after reset: first item reaches the tap after 16 shifts
        for (int k = 1; k <= 16; k++) begin
            step(SHIFT, 5'd3, 8'(k), 1'b1,
                 mk("reset_len16", (k == 16) ? 8'h01 : 8'h00, k == 16, 5'(k), k == 16, 0, 0));
        end

        step(CLEAR, 5'd4, 8'h00, 1'b0, mk("clear_len4", 8'h00, 0, 0, 0, 1, 0));
        step(SHIFT, 5'd9, 8'hA1, 1'b1, mk("shift_1", 8'h00, 0, 1, 0, 0, 0));
        step(SHIFT, 5'd9, 8'hB2, 1'b1, mk("shift_2", 8'h00, 0, 2, 0, 0, 0));
        step(SHIFT, 5'd9, 8'hC3, 1'b1, mk("shift_3", 8'h00, 0, 3, 0, 0, 0));
        step(SHIFT, 5'd9, 8'hD4, 1'b1, mk("shift_4", 8'hA1, 1, 4, 1, 0, 0));

        step(ROTATE, 5'd0, 8'hFF, 1'b0, mk("rot_1", 8'hB2, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'hFF, 1'b0, mk("rot_2", 8'hC3, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'hFF, 1'b0, mk("rot_3", 8'hD4, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'hFF, 1'b0, mk("rot_4", 8'hA1, 1, 4, 1, 0, 1));
        step(ROTATE, 5'd0, 8'hFF, 1'b0, mk("rot_5", 8'hB2, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'hFF, 1'b0, mk("rot_6", 8'hC3, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'hFF, 1'b0, mk("rot_7", 8'hD4, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'hFF, 1'b0, mk("rot_8", 8'hA1, 1, 4, 1, 0, 1));

        // hold in the middle of a rotation preserves pos and data
        step(ROTATE, 5'd0, 8'h00, 1'b0, mk("hmr_rot1", 8'hB2, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'h00, 1'b0, mk("hmr_rot2", 8'hC3, 1, 4, 1, 0, 0));
        step(HOLD,   5'd1, 8'h77, 1'b1, mk("hmr_hold1", 8'hC3, 1, 4, 1, 0, 0));
        step(HOLD,   5'd1, 8'h77, 1'b1, mk("hmr_hold2", 8'hC3, 1, 4, 1, 0, 0));
        step(HOLD,   5'd1, 8'h77, 1'b1, mk("hmr_hold3", 8'hC3, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'h00, 1'b0, mk("hmr_rot3", 8'hD4, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'h00, 1'b0, mk("hmr_rot4", 8'hA1, 1, 4, 1, 0, 1));
        step(HOLD,   5'd0, 8'h00, 1'b0, mk("hmr_hold_after", 8'hA1, 1, 4, 1, 0, 0));

        // len = 0 clamps to 1; len outside CLEAR is ignored
        step(CLEAR, 5'd0, 8'h00, 1'b0, mk("clamp0_clear", 8'h00, 0, 0, 0, 1, 0));
        step(SHIFT, 5'd7, 8'h11, 1'b1, mk("clamp0_s1", 8'h11, 1, 1, 1, 0, 0));
        step(SHIFT, 5'd7, 8'h22, 1'b0, mk("clamp0_s2", 8'h22, 0, 0, 0, 1, 0));
        step(SHIFT, 5'd7, 8'h33, 1'b1, mk("clamp0_s3", 8'h33, 1, 1, 1, 0, 0));
        step(ROTATE, 5'd7, 8'h00, 1'b0, mk("clamp0_rot", 8'h33, 1, 1, 1, 0, 1));

        // len = 20 clamps to DEPTH
        step(CLEAR, 5'd20, 8'h00, 1'b0, mk("clamp20_clear", 8'h00, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 16; k++) begin
            step(SHIFT, 5'd2, 8'(8'h40 + k), 1'b1,
                 mk("clamp20_shift", (k == 16) ? 8'h41 : 8'h00, k == 16, 5'(k), k == 16, 0, 0));
        end

        // reset in the middle of a rotation (pos = 2)
        step(CLEAR, 5'd4, 8'h00, 1'b0, mk("mid_clear", 8'h00, 0, 0, 0, 1, 0));
        step(SHIFT, 5'd0, 8'hE1, 1'b1, mk("mid_s1", 8'h00, 0, 1, 0, 0, 0));
        step(SHIFT, 5'd0, 8'hE2, 1'b1, mk("mid_s2", 8'h00, 0, 2, 0, 0, 0));
        step(SHIFT, 5'd0, 8'hE3, 1'b1, mk("mid_s3", 8'h00, 0, 3, 0, 0, 0));
        step(SHIFT, 5'd0, 8'hE4, 1'b1, mk("mid_s4", 8'hE1, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'h00, 1'b0, mk("mid_r1", 8'hE2, 1, 4, 1, 0, 0));
        step(ROTATE, 5'd0, 8'h00, 1'b0, mk("mid_r2", 8'hE3, 1, 4, 1, 0, 0));
        mode = ROTATE;
        #2 rst_n = 1'b0;
        #1;
        sb.push_back(mk("mid_reset_async", 8'h00, 0, 0, 0, 1, 0));
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        // pos restarts at 0 and len_q is 16: lap only after the 16th rotate edge
        for (int k = 1; k <= 16; k++) begin
            step(ROTATE, 5'd4, 8'hFF, 1'b1,
                 mk("mid_post_rot", 8'h00, 0, 0, 0, 1, k == 16));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
